// File: rtl/ss_seq.sv
// ---------------------------------------------------------------------------
// ss_seq -- save-state sequencer for the mapper register file.
//
// Save: walks the mapper through the index byte (IDX_ADDR) followed by
// registers 0..SS_LAST. Each byte read on ss_rdat is offered to the host on
// the tx channel.
// Load: takes the same byte stream from the host on the rx channel. The
// leading index byte must equal map_idx. Each following byte is written
// into registers 0..SS_LAST in order.
//
// Stream layout, both directions:
//   byte 0           = mapper index
//   bytes 1..LAST+1  = registers 0..SS_LAST
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start_save, start_load  one-cycle start pulses; honoured only in IDLE;
//                           save wins if both are high
//   abort                   return to IDLE and flag err (no effect in IDLE)
//   map_idx                 index value a load stream must start with
//   busy, done, err         status: busy outside IDLE, done pulse, sticky err
//   ss_act/ss_we/ss_addr/
//   ss_wdat/ss_rdat         mapper save-state port
//   tx_dat/tx_valid/tx_ready  byte stream to the host (valid/ready)
//   rx_dat/rx_valid/rx_ready  byte stream from the host (valid/ready)
// ---------------------------------------------------------------------------
module ss_seq #(
  parameter int SS_LAST  = 10,
  parameter int IDX_ADDR = 127
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_save,
  input  logic       start_load,
  input  logic       abort,
  input  logic [7:0] map_idx,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       ss_act,
  output logic       ss_we,
  output logic [7:0] ss_addr,
  output logic [7:0] ss_wdat,
  input  logic [7:0] ss_rdat,
  output logic [7:0] tx_dat,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_dat,
  input  logic       rx_valid,
  output logic       rx_ready
);

  localparam logic [7:0] LAST_A = 8'(SS_LAST);
  localparam logic [7:0] IDX_A  = 8'(IDX_ADDR);

  typedef enum logic [2:0] {
    IDLE,
    SV_ADDR,
    SV_CAP,
    SV_PUSH,
    LD_WAIT,
    LD_WR,
    FIN
  } state_t;

  state_t     state_q, state_d;
  // addr_q is the save address and also the load pointer. During a load it
  // holds IDX_A only while the index byte is still expected.
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdat_q, wdat_d;
  logic [7:0] tx_dat_q, tx_dat_d;
  logic       err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      addr_q   <= 8'd0;
      wdat_q   <= 8'd0;
      tx_dat_q <= 8'd0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdat_q   <= wdat_d;
      tx_dat_q <= tx_dat_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdat_d   = wdat_q;
    tx_dat_d = tx_dat_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (start_save) begin
          state_d = SV_ADDR;
          addr_d  = IDX_A;
          err_d   = 1'b0;
        end else if (start_load) begin
          state_d = LD_WAIT;
          addr_d  = IDX_A;
          err_d   = 1'b0;
        end
      end

      // ss_rdat is combinational on ss_addr; give it one cycle to settle.
      SV_ADDR: state_d = SV_CAP;

      SV_CAP: begin
        tx_dat_d = ss_rdat;
        state_d  = SV_PUSH;
      end

      SV_PUSH: begin
        if (tx_ready) begin
          if (addr_q == LAST_A) begin
            state_d = FIN;
          end else begin
            // The index byte goes first, then the registers from 0 upward.
            addr_d  = (addr_q == IDX_A) ? 8'd0 : addr_q + 8'd1;
            state_d = SV_ADDR;
          end
        end
      end

      LD_WAIT: begin
        if (rx_valid) begin
          if (addr_q == IDX_A) begin
            if (rx_dat != map_idx) begin
              // Wrong mapper: abandon before touching any register.
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              addr_d = 8'd0;
            end
          end else begin
            wdat_d  = rx_dat;
            state_d = LD_WR;
          end
        end
      end

      LD_WR: begin
        if (addr_q == LAST_A) begin
          state_d = FIN;
        end else begin
          addr_d  = addr_q + 8'd1;
          state_d = LD_WAIT;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FIN);
  assign err      = err_q;
  assign ss_act   = (state_q != IDLE) && (state_q != FIN);
  assign ss_we    = (state_q == LD_WR);
  assign ss_addr  = addr_q;
  assign ss_wdat  = wdat_q;
  assign tx_dat   = tx_dat_q;
  assign tx_valid = (state_q == SV_PUSH);
  assign rx_ready = (state_q == LD_WAIT);

endmodule

// File: tb/tb_ss_seq.sv
// ---------------------------------------------------------------------------
// tb_ss_seq -- directed testbench for ss_seq (SS_LAST=10, IDX_ADDR=127).
// A small mapper model returns addr+0x40, or 0x30 at the index address.
// Monitors log accepted tx bytes, mapper writes, done pulses and handshake
// stability. Each test task checks its own expectations against those logs.
// ---------------------------------------------------------------------------
module tb_ss_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_save, start_load, abort;
  logic [7:0] map_idx;
  logic       busy, done, err, ss_act, ss_we;
  logic [7:0] ss_addr, ss_wdat, ss_rdat, tx_dat, rx_dat;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ss_seq dut (
    .clk(clk), .rst_n(rst_n),
    .start_save(start_save), .start_load(start_load), .abort(abort),
    .map_idx(map_idx),
    .busy(busy), .done(done), .err(err),
    .ss_act(ss_act), .ss_we(ss_we), .ss_addr(ss_addr),
    .ss_wdat(ss_wdat), .ss_rdat(ss_rdat),
    .tx_dat(tx_dat), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_dat(rx_dat), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  // Mapper read model.
  assign ss_rdat = (ss_addr == 8'd127) ? 8'h30 : ss_addr + 8'h40;

  // ---------------- monitors ----------------
  logic [7:0] tx_buf [256];
  logic [7:0] wr_addr [256];
  logic [7:0] wr_dat [256];
  int   tx_cnt = 0, wr_cnt = 0, done_cnt = 0, rx_idx = 0;
  int   bad_we = 0, dbl_we = 0, stab_err = 0;
  logic we_prev = 1'b0, hold_prev = 1'b0;
  logic [7:0] hold_dat = 8'd0;

  always @(posedge clk) begin
    if (tx_valid && tx_ready) begin
      tx_buf[tx_cnt & 255] <= tx_dat;
      tx_cnt <= tx_cnt + 1;
    end
    if (ss_we) begin
      wr_addr[wr_cnt & 255] <= ss_addr;
      wr_dat[wr_cnt & 255]  <= ss_wdat;
      wr_cnt <= wr_cnt + 1;
      if (ss_addr == 8'd127) bad_we <= bad_we + 1;
      if (we_prev) dbl_we <= dbl_we + 1;
    end
    we_prev <= ss_we;
    if (done) done_cnt <= done_cnt + 1;
    if (rx_valid && rx_ready) rx_idx <= rx_idx + 1;
    // A byte offered but not taken must still be offered, unchanged, next edge.
    if (hold_prev && !(tx_valid && tx_dat == hold_dat)) stab_err <= stab_err + 1;
    hold_prev <= tx_valid && !tx_ready;
    hold_dat  <= tx_dat;
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] strm [16];
  int         nbytes;
  int         abort_at;

  // Start a save (optionally with start_load high too) and run until done.
  // n is the cycle index at which done was seen (start cycle = 0).
  task automatic run_save(input bit toggle, input bit both,
                          output int n, output logic err_at1);
    @(negedge clk);
    start_save = 1'b1;
    start_load = both;
    if (!toggle) tx_ready = 1'b1;
    @(negedge clk);
    start_save = 1'b0;
    start_load = 1'b0;
    n = 1;
    err_at1 = err;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
      if (toggle) tx_ready = ~tx_ready;
    end
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL save_timeout: done never seen within %0d cycles", n);
    end
    @(negedge clk);
    tx_ready = 1'b1;
  endtask

  // Start a load fed from strm[0..nbytes-1]; abort once abort_at bytes are taken.
  task automatic run_load(output int n, output int done_n);
    int k;
    int rx_base;
    @(negedge clk);
    start_load = 1'b1;
    rx_base  = rx_idx;
    rx_valid = 1'b1;
    rx_dat   = strm[0];
    @(negedge clk);
    start_load = 1'b0;
    n = 1;
    done_n = -1;
    while (busy === 1'b1 && n < 200) begin
      if (done === 1'b1) done_n = n;
      k = rx_idx - rx_base;
      if (abort_at >= 0 && k >= abort_at) begin
        rx_valid = 1'b0;
        abort    = 1'b1;
      end else begin
        rx_valid = (k < nbytes);
        rx_dat   = strm[(k < 16) ? k : 0];
      end
      @(negedge clk);
      n++;
      abort = 1'b0;
    end
    rx_valid = 1'b0;
    if (n >= 200) begin
      tests++; fails++;
      $display("FAIL load_timeout: busy still high after %0d cycles", n);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [45:0] outs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    outs = {busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, tx_dat, tx_valid, rx_ready, 13'd0, 1'b0};
    tests++;
    if (outs !== 46'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 0", outs);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b required 0", busy);
    end
    // abort while idle must do nothing
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    tests++;
    if ({busy, err} !== 2'b00) begin
      fails++;
      $display("FAIL abort_idle: busy,err=%b required 00", {busy, err});
    end
  endtask

  task automatic check_save_stream(input string name, input int base);
    logic [7:0] exp;
    tests++;
    if (tx_cnt - base !== 12) begin
      fails++;
      $display("FAIL %s_count: %0d bytes required 12", name, tx_cnt - base);
    end
    for (int i = 0; i < 12; i++) begin
      exp = (i == 0) ? 8'h30 : 8'h40 + 8'(i - 1);
      tests++;
      if (tx_buf[(base + i) & 255] !== exp) begin
        fails++;
        $display("FAIL %s_byte%0d: got %h required %h", name, i, tx_buf[(base + i) & 255], exp);
      end
    end
  endtask

  task automatic test_save();
    int n, tb0, wb0, db0;
    logic e1;
    tb0 = tx_cnt; wb0 = wr_cnt; db0 = done_cnt;
    run_save(1'b0, 1'b0, n, e1);
    $display("[TB] save tx_ready=1: done at cycle %0d", n);
    tests++;
    if (n !== 37) begin
      fails++;
      $display("FAIL save_latency: done at cycle %0d required 37", n);
    end
    check_save_stream("save", tb0);
    tests++;
    if (done_cnt - db0 !== 1) begin
      fails++;
      $display("FAIL save_done_once: %0d pulses required 1", done_cnt - db0);
    end
    tests++;
    if (wr_cnt - wb0 !== 0) begin
      fails++;
      $display("FAIL save_no_we: %0d writes required 0", wr_cnt - wb0);
    end
  endtask

  task automatic test_save_backpressure();
    int n, tb0, sb0;
    logic e1;
    tb0 = tx_cnt; sb0 = stab_err;
    tx_ready = 1'b0;
    run_save(1'b1, 1'b0, n, e1);
    $display("[TB] save toggled tx_ready: done at cycle %0d", n);
    check_save_stream("bp", tb0);
    tests++;
    if (stab_err - sb0 !== 0) begin
      fails++;
      $display("FAIL bp_stable: %0d unstable holds required 0", stab_err - sb0);
    end
  endtask

  task automatic test_load();
    int n, dn, wb0, db0, dw0;
    wb0 = wr_cnt; db0 = done_cnt; dw0 = dbl_we;
    map_idx = 8'd33;
    strm[0] = 8'h21;
    for (int i = 0; i < 11; i++) strm[i + 1] = 8'(i);
    nbytes = 12;
    abort_at = -1;
    run_load(n, dn);
    $display("[TB] load: done at cycle %0d, %0d writes", dn, wr_cnt - wb0);
    tests++;
    if (wr_cnt - wb0 !== 11) begin
      fails++;
      $display("FAIL load_writes: %0d required 11", wr_cnt - wb0);
    end
    for (int i = 0; i < 11; i++) begin
      tests++;
      if (wr_addr[(wb0 + i) & 255] !== 8'(i) || wr_dat[(wb0 + i) & 255] !== 8'(i)) begin
        fails++;
        $display("FAIL load_wr%0d: addr %h data %h required %h", i,
                 wr_addr[(wb0 + i) & 255], wr_dat[(wb0 + i) & 255], 8'(i));
      end
    end
    tests++;
    if (dbl_we - dw0 !== 0) begin
      fails++;
      $display("FAIL load_we_width: %0d multi-cycle strobes required 0", dbl_we - dw0);
    end
    tests++;
    if (done_cnt - db0 !== 1 || dn !== 24) begin
      fails++;
      $display("FAIL load_done: %0d pulses at cycle %0d required 1 at 24", done_cnt - db0, dn);
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL load_err: err=%b required 0", err);
    end
  endtask

  task automatic test_load_mismatch();
    int n, dn, wb0, db0;
    wb0 = wr_cnt; db0 = done_cnt;
    map_idx = 8'd33;
    strm[0] = 8'h30;
    for (int i = 0; i < 11; i++) strm[i + 1] = 8'(i);
    nbytes = 12;
    abort_at = -1;
    run_load(n, dn);
    $display("[TB] load bad index: busy dropped at cycle %0d", n);
    tests++;
    if (n !== 2) begin
      fails++;
      $display("FAIL mismatch_busy: busy low at cycle %0d required 2", n);
    end
    tests++;
    if ({err, wr_cnt - wb0, done_cnt - db0} !== {1'b1, 32'd0, 32'd0}) begin
      fails++;
      $display("FAIL mismatch_result: err=%b writes=%0d done=%0d required 1,0,0",
               err, wr_cnt - wb0, done_cnt - db0);
    end
  endtask

  task automatic test_abort();
    int n, dn, wb0, db0, tb0;
    logic e1;
    wb0 = wr_cnt; db0 = done_cnt;
    map_idx = 8'd33;
    strm[0] = 8'h21;
    for (int i = 0; i < 11; i++) strm[i + 1] = 8'(i);
    nbytes = 12;
    abort_at = 5;
    run_load(n, dn);
    abort_at = -1;
    $display("[TB] load aborted after 5 bytes: %0d writes", wr_cnt - wb0);
    tests++;
    if ({ss_act, err} !== 2'b01) begin
      fails++;
      $display("FAIL abort_state: ss_act,err=%b required 01", {ss_act, err});
    end
    tests++;
    if (wr_cnt - wb0 !== 4 || done_cnt - db0 !== 0) begin
      fails++;
      $display("FAIL abort_writes: writes=%0d done=%0d required 4,0", wr_cnt - wb0, done_cnt - db0);
    end
    tb0 = tx_cnt;
    run_save(1'b0, 1'b0, n, e1);
    $display("[TB] save after abort: done at cycle %0d", n);
    tests++;
    if (e1 !== 1'b0 || err !== 1'b0) begin
      fails++;
      $display("FAIL abort_err_clear: err=%b/%b required 0", e1, err);
    end
    check_save_stream("post_abort", tb0);
  endtask

  task automatic test_back_to_back();
    int n, tb0, wb0;
    logic e1;
    logic [45:0] outs;
    // Stall a save in SV_PUSH, then reset mid-cycle.
    @(negedge clk);
    tx_ready = 1'b0;
    start_save = 1'b1;
    @(negedge clk);
    start_save = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, tx_valid, ss_addr} !== {2'b11, 8'd127}) begin
      fails++;
      $display("FAIL push_hold: busy,tx_valid,addr=%b,%b,%h required 1,1,7f", busy, tx_valid, ss_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    outs = {busy, done, err, ss_act, ss_we, ss_addr, ss_wdat, tx_dat, tx_valid, rx_ready, 14'd0};
    tests++;
    if (outs !== 46'd0) begin
      fails++;
      $display("FAIL async_reset: got %h required 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tb0 = tx_cnt; wb0 = wr_cnt;
    run_save(1'b0, 1'b1, n, e1);
    $display("[TB] save with both starts: done at cycle %0d", n);
    tests++;
    if (n !== 37 || wr_cnt - wb0 !== 0) begin
      fails++;
      $display("FAIL both_start: done cycle %0d writes %0d required 37,0", n, wr_cnt - wb0);
    end
    check_save_stream("both", tb0);
  endtask

  initial begin
    start_save = 1'b0; start_load = 1'b0; abort = 1'b0;
    map_idx = 8'd0; tx_ready = 1'b1; rx_dat = 8'd0; rx_valid = 1'b0;
    nbytes = 0; abort_at = -1;
    test_reset();
    test_save();
    test_save_backpressure();
    test_load();
    test_load_mismatch();
    test_abort();
    test_back_to_back();
    tests++;
    if (bad_we !== 0) begin
      fails++;
      $display("FAIL idx_never_written: %0d writes to 127 required 0", bad_we);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ss_seq.md
Name: ss_seq

Overview:
- Save-state sequencer for the mapper register file.
- Walks the mapper's ss_addr/ss_rdat/ss_we port to serialise all mapper state into a byte stream toward the host (save), or to replay a byte stream back into the mapper (load).
- Sits between the host-side save-state channel and any mapper exposing the standard ss_ctrl port.
- Owns ss_act for the whole operation.

Parameters:
- SS_LAST, 10, highest contiguous register index (registers 0..SS_LAST are transferred).
- IDX_ADDR, 127, ss_addr of the read-only mapper index byte.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start_save  in  1  one-cycle pulse; begin save (ignored unless IDLE).
- start_load  in  1  one-cycle pulse; begin load (ignored unless IDLE; start_save wins if both).
- abort  in  1  return to IDLE at next edge; sets err.
- map_idx  in  8  expected mapper index for load check.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky; cleared by next accepted start.
- ss_act  out  1  mapper save-state access enable.
- ss_we  out  1  mapper register write strobe.
- ss_addr  out  8  mapper register index.
- ss_wdat  out  8  write data to mapper.
- ss_rdat  in  8  read data from mapper (combinational on ss_addr).
- tx_dat  out  8  stream byte to host.
- tx_valid  out  1  tx_dat valid.
- tx_ready  in  1  host accepts tx byte.
- rx_dat  in  8  stream byte from host.
- rx_valid  in  1  rx_dat valid.
- rx_ready  out  1  ss_seq accepts rx byte.

Behaviour:
- Reset values: all outputs 0; state IDLE.
- Stream format, both directions: byte0 = mapper index; bytes 1..SS_LAST+1 = registers 0..SS_LAST in order. Total SS_LAST+2 bytes.
- Handshake: a transfer occurs on a clk edge with valid&ready both high. tx_dat/tx_valid are held stable until accepted. rx_ready is high only in LD_WAIT.

States:
- IDLE
  - start_save -> SV_ADDR with ss_addr=IDX_ADDR.
  - start_load -> LD_WAIT with ptr=IDX.
- SV_ADDR: ss_act=1, ss_addr valid. One settle cycle -> SV_CAP.
- SV_CAP: tx_dat <= ss_rdat, tx_valid <= 1 -> SV_PUSH.
- SV_PUSH: hold until tx_ready.
  - On accept: if ss_addr==SS_LAST -> FIN.
  - Else ss_addr <= (ss_addr==IDX_ADDR ? 0 : ss_addr+1) -> SV_ADDR.
- LD_WAIT: rx_ready=1. On accept, latch byte.
  - If ptr==IDX: mismatch with map_idx -> err=1, IDLE, no writes issued. Match -> ptr=0, stay.
  - Else -> LD_WR.
- LD_WR: ss_addr=ptr, ss_wdat=byte, ss_we=1 for exactly one cycle.
  - If ptr==SS_LAST -> FIN.
  - Else ptr+1 -> LD_WAIT.
- FIN: done=1 one cycle, ss_act=0 -> IDLE.

Outputs and timing:
- ss_act is 1 from the cycle after start through the last SV_PUSH/LD_WR inclusive, and 0 in IDLE/FIN.
- IDX_ADDR is never written; ss_we is never high while ss_addr==IDX_ADDR.
- Save latency with tx_ready tied high: 3 cycles per byte, i.e. 3*(SS_LAST+2)+1 cycles from start to done.
- Load with rx_valid tied high: 1 cycle for the index byte, then 2 cycles per register.

Boundary conditions:
- abort in any state: tx_valid, ss_we and ss_act drop next edge; err=1; no done. abort in IDLE: no effect.
- rst_n low mid-operation: immediate IDLE, outputs 0; partial mapper writes are not undone.
- Starts while busy are ignored.
- Address counter is 8-bit and never exceeds SS_LAST.
- SS_LAST=0 is legal: 2-byte stream.

Test Plan:
- Save, tx_ready=1, SS_LAST=10, mapper model returns ss_rdat=addr+0x40 and 48 at addr 127 -> tx stream 0x30,0x40..0x4A (12 bytes); done pulses once at cycle 37; ss_we never high.
- Save with tx_ready toggling every other cycle -> identical byte sequence; tx_dat stable while tx_valid&!tx_ready; no byte duplicated or dropped.
- Load, map_idx=33, rx stream 0x21,0x00..0x0A -> 11 ss_we pulses at addr 0..10 with ss_wdat=addr, one cycle each; done=1; err=0.
- Load with index byte 0x30 while map_idx=33 -> err=1, zero ss_we pulses, busy drops next cycle, no done.
- abort asserted after 5th rx byte of a load -> ss_act=0 next edge, err=1, exactly 4 writes issued; a subsequent start_save clears err and completes normally.
- rst_n pulsed low during SV_PUSH -> all outputs 0 asynchronously; start_save and start_load pulsed in the same cycle after release -> a save is performed.
